gate_chip_checker: RTL and testbench
====================================

# gate_chip_checker

Parametrised functional tester for 74xx-series DIP logic chips made of identical gates, such as the 7400, 7402, 7408, 7410 and 7411. It sweeps every input combination through every gate on the chip. For each combination it waits a settle interval, samples the synchronised gate outputs and compares them against a truth-table parameter. At the end it reports pass/fail plus the first failure location. It sits under the chip-checker top as the common replacement for the per-part checker modules. The top maps `drive_o`, `drive_en_o` and `sense_i` onto the physical DIP pins.

## Interface
- `NUM_GATES`, default 4: number of gates on the chip, range 1..6.
- `GATE_INPUTS`, default 2: inputs per gate, range 1..4.
- `TRUTH_TABLE`, default 4'b0111 (NAND): `2**GATE_INPUTS` bits; bit i is the expected output when the gate's input vector equals i (input 0 = LSB).
- `SETTLE_CYCLES`, default 50000: drive-to-sample wait in Clk cycles, must be ≥ 3.
- `Clk`, input, 1: system clock (50 MHz).
- `Reset`, input, 1: synchronous reset, active-high.
- `Run`, input, 1: start request, level-sensitive, active-high.
- `sense_i`, input, `NUM_GATES`: gate outputs read from the chip, asynchronous.
- `drive_o`, output, `NUM_GATES*GATE_INPUTS`: values driven onto gate inputs; gate g occupies bits `[g*GATE_INPUTS +: GATE_INPUTS]`.
- `drive_en_o`, output, 1: when high, the top drives `drive_o` onto the pins; otherwise the pins are high-Z.
- `Done`, output, 1: sweep complete; remains high while in DONE.
- `RSLT`, output, 1: 1 = chip passed; valid while `Done` is high.
- `fail_mask`, output, `NUM_GATES`: bit g set if gate g mismatched on any vector.
- `fail_gate`, output, `max(1,$clog2(NUM_GATES))`: lowest-index failing gate at the first failing step.
- `fail_vec`, output, `GATE_INPUTS`: the vector applied to `fail_gate` at that first failing step.
- `busy`, output, 1: high in DRIVE or SAMPLE.
- `state_o`, output, 3: state encoding for the HEX debug display (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3).

## Operation
- `sense_i` passes through a 2-flop synchroniser before any comparison.
- The vector counter `v` is `GATE_INPUTS` bits wide and steps 0 .. `2**GATE_INPUTS-1`. In the default build every gate receives `v`.
- **IDLE.** `drive_en_o`=0, `drive_o`=0, `Done`=0.
  - When `Run`=1: clear `v`, `fail_mask`, `fail_gate`, `fail_vec` and the settle counter, then go to DRIVE.
- **DRIVE.** `drive_en_o`=1 and `drive_o` presents the current vector(s).
  - The settle counter counts 0 .. `SETTLE_CYCLES-1`. On the last count, go to SAMPLE.
- **SAMPLE** (1 cycle). For each gate g, `mismatch[g]` = `sync_sense[g]` XOR `TRUTH_TABLE[vec_g]`.
  - `fail_mask` accumulates `mismatch` by OR.
  - On the first SAMPLE with a nonzero `mismatch`, capture the lowest set g into `fail_gate` and `vec_g` into `fail_vec`. Later failures do not overwrite the capture.
  - If `v` is at its maximum, go to DONE. Otherwise increment `v`, clear the settle counter and return to DRIVE.
- **DONE.** `drive_en_o`=0, `drive_o`=0, `Done`=1, `RSLT` = (`fail_mask`==0).
  - Stay in DONE while `Run`=1; go to IDLE when `Run`=0.
  - A held `Run` never restarts the sweep.
- The sweep always runs all vectors. There is no early exit on failure.
- `Run` deasserting during DRIVE or SAMPLE is ignored; the sweep completes.
- `Reset` takes effect at any point, including mid-sweep. On the next edge:
  - state goes to IDLE;
  - all outputs go to 0, so `drive_en_o`=0 and the pins release;
  - the synchroniser flops, counters and captured failure data are cleared.
- Reset wins over a simultaneous `Run`.

## Timing
- Reset values: `drive_o`=0, `drive_en_o`=0, `Done`=0, `RSLT`=0, `fail_mask`=0, `fail_gate`=0, `fail_vec`=0, `busy`=0, `state_o`=0.
- Each vector takes `SETTLE_CYCLES` DRIVE cycles plus 1 SAMPLE cycle.
- `Done` rises `1 + 2**GATE_INPUTS*(SETTLE_CYCLES+1)` edges after the edge that samples `Run`=1 in IDLE.
- With the defaults this is 200005 cycles, about 4.0 ms.
- Sampling is guaranteed at least 3 cycles after the drive change, which covers the 2-flop synchroniser latency.
- `drive_en_o` drops on the same edge `Done` rises.
- All outputs are registered.

## Configuration
- `GATE_CHK_ISOLATION_EN` defined:
  - gate g receives `vec_g` = (`v` + g) mod `2**GATE_INPUTS`;
  - neighbouring gates therefore see different inputs on every step, which exposes inter-gate shorts and bridged pins;
  - expected outputs use each gate's own `vec_g`.
- Not defined: `vec_g` = `v` for all g. The block is smaller, and shorts between gates carrying identical signals go undetected.

## Test plan
- **Good part.** NAND model, defaults except `SETTLE_CYCLES`=4, `Run` pulsed high:
  - `Done` rises 21 cycles after `Run` is sampled;
  - `RSLT`=1, `fail_mask`=4'b0000;
  - `drive_o` steps 0x00, 0x55, 0xAA, 0xFF.
- **Stuck-at fault.** Same setup with gate 2 output stuck at 1:
  - `RSLT`=0, `fail_mask`=4'b0100, `fail_gate`=2, `fail_vec`=2'b11.
- **Handshake.**
  - Hold `Run`=1 through DONE for 100 cycles: `Done` stays 1 and no second sweep occurs.
  - Drop `Run`: IDLE next cycle.
  - Raise `Run` again: a fresh sweep with `fail_mask` cleared.
- **Reset mid-sweep.** Assert `Reset` in cycle 10 of a sweep:
  - the next edge gives `state_o`=0 and `drive_en_o`=0 with all outputs 0;
  - a subsequent run passes normally.
- **3-input AND (7411).** `NUM_GATES`=3, `GATE_INPUTS`=3, `TRUTH_TABLE`=8'h80, `SETTLE_CYCLES`=4:
  - 8 vectors, `Done` at cycle 41, `RSLT`=1.
- **Isolation feature.** Model a short that ORs gate 0 output into gate 1 output, and run the NAND setup twice:
  - with `GATE_CHK_ISOLATION_EN`: `RSLT`=0, `fail_mask[1]`=1;
  - without it: `RSLT`=1.

Source files
------------

// File: rtl/gate_chip_checker_if.sv
// gate_chip_checker_if: bundles the run/result handshake and the DIP pin
// signals of gate_chip_checker. The checker connects through the slave
// modport. The chip-checker top (or a bench) connects through the master
// modport.
interface gate_chip_checker_if #(
    parameter int NUM_GATES   = 4,
    parameter int GATE_INPUTS = 2
);
    localparam int GATE_IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

    logic                               Run;
    logic [NUM_GATES-1:0]               sense_i;
    logic [NUM_GATES*GATE_INPUTS-1:0]   drive_o;
    logic                               drive_en_o;
    logic                               Done;
    logic                               RSLT;
    logic [NUM_GATES-1:0]               fail_mask;
    logic [GATE_IDX_W-1:0]              fail_gate;
    logic [GATE_INPUTS-1:0]             fail_vec;
    logic                               busy;
    logic [2:0]                         state_o;

    modport master (
        output Run, sense_i,
        input  drive_o, drive_en_o, Done, RSLT, fail_mask, fail_gate,
               fail_vec, busy, state_o
    );

    modport slave (
        input  Run, sense_i,
        output drive_o, drive_en_o, Done, RSLT, fail_mask, fail_gate,
               fail_vec, busy, state_o
    );
endinterface

// File: rtl/gate_chip_checker.sv
// gate_chip_checker: functional tester for 74xx chips built from identical
// gates. It sweeps every input vector through all gates. For each vector it
// waits SETTLE_CYCLES, then compares the synchronised gate outputs against
// TRUTH_TABLE. At the end it reports pass/fail and the first failing
// gate/vector.
//
// Optional feature macro: GATE_CHK_ISOLATION_EN. When it is defined, gate g
// is driven with (v + g) so that neighbouring gates never share inputs. This
// exposes shorts between them.
//
// Every output is registered from the current state. As a result, Done and
// the pin-release of drive_en_o show up one edge after the FSM enters DONE.
module gate_chip_checker #(
    parameter int                          NUM_GATES     = 4,
    parameter int                          GATE_INPUTS   = 2,
    parameter logic [(2**GATE_INPUTS)-1:0] TRUTH_TABLE   = 4'b0111,
    parameter int                          SETTLE_CYCLES = 50000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    gate_chip_checker_if.slave    bus
);
    localparam int GATE_IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam int CNT_W      = $clog2(SETTLE_CYCLES);
    localparam int DRIVE_W    = NUM_GATES * GATE_INPUTS;

    localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [GATE_INPUTS-1:0] VEC_ONE     = GATE_INPUTS'(1);
    localparam logic [GATE_INPUTS-1:0] VEC_MAX     = {GATE_INPUTS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DONE   = 3'd3
    } state_t;

    state_t                  state_r, state_next_s;
    logic [GATE_INPUTS-1:0]  v_r, v_next_s;
    logic [CNT_W-1:0]        settle_r, settle_next_s;
    logic [NUM_GATES-1:0]    sync1_r, sync2_r;
    logic [NUM_GATES-1:0]    fail_mask_r, fail_mask_next_s;
    logic [GATE_IDX_W-1:0]   fail_gate_r, fail_gate_next_s;
    logic [GATE_INPUTS-1:0]  fail_vec_r, fail_vec_next_s;

    logic [GATE_INPUTS-1:0]  vec_s [NUM_GATES];
    logic [DRIVE_W-1:0]      drive_vec_s;
    logic [NUM_GATES-1:0]    mismatch_s;
    logic [GATE_IDX_W-1:0]   first_gate_s;
    logic [GATE_INPUTS-1:0]  first_vec_s;

    logic [DRIVE_W-1:0]      drive_r;
    logic                    drive_en_r;
    logic                    done_r;
    logic                    rslt_r;
    logic                    busy_r;
    logic [2:0]              state_o_r;

    // Per-gate input vector. Offset by gate index when isolation is enabled.
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
`ifdef GATE_CHK_ISOLATION_EN
            vec_s[g] = v_r + GATE_INPUTS'(g);
`else
            vec_s[g] = v_r;
`endif
        end
    end

    // Pack the per-gate vectors onto the pin bus and compare against the table.
    always_comb begin
        drive_vec_s  = {DRIVE_W{1'b0}};
        mismatch_s   = {NUM_GATES{1'b0}};
        first_gate_s = {GATE_IDX_W{1'b0}};
        first_vec_s  = {GATE_INPUTS{1'b0}};
        for (int g = 0; g < NUM_GATES; g++) begin
            drive_vec_s[g*GATE_INPUTS +: GATE_INPUTS] = vec_s[g];
            mismatch_s[g] = sync2_r[g] ^ TRUTH_TABLE[vec_s[g]];
        end
        // Descending scan so the lowest mismatching gate is the final winner.
        for (int g = NUM_GATES - 1; g >= 0; g--) begin
            first_gate_s = mismatch_s[g] ? GATE_IDX_W'(g) : first_gate_s;
            first_vec_s  = mismatch_s[g] ? vec_s[g]       : first_vec_s;
        end
    end

    // Next-state, vector/settle counters and failure capture.
    always_comb begin
        state_next_s     = state_r;
        v_next_s         = v_r;
        settle_next_s    = settle_r;
        fail_mask_next_s = fail_mask_r;
        fail_gate_next_s = fail_gate_r;
        fail_vec_next_s  = fail_vec_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Run) begin
                    state_next_s     = ST_DRIVE;
                    v_next_s         = {GATE_INPUTS{1'b0}};
                    settle_next_s    = {CNT_W{1'b0}};
                    fail_mask_next_s = {NUM_GATES{1'b0}};
                    fail_gate_next_s = {GATE_IDX_W{1'b0}};
                    fail_vec_next_s  = {GATE_INPUTS{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (settle_r == SETTLE_LAST) begin
                    state_next_s = ST_SAMPLE;
                end else begin
                    settle_next_s = settle_r + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                fail_mask_next_s = fail_mask_r | mismatch_s;
                // An all-zero mask means no failure has been captured yet.
                if ((mismatch_s != {NUM_GATES{1'b0}}) &&
                    (fail_mask_r == {NUM_GATES{1'b0}})) begin
                    fail_gate_next_s = first_gate_s;
                    fail_vec_next_s  = first_vec_s;
                end else begin
                    fail_gate_next_s = fail_gate_r;
                    fail_vec_next_s  = fail_vec_r;
                end
                if (v_r == VEC_MAX) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s  = ST_DRIVE;
                    v_next_s      = v_r + VEC_ONE;
                    settle_next_s = {CNT_W{1'b0}};
                end
            end
            ST_DONE: begin
                if (bus.Run) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            v_r         <= {GATE_INPUTS{1'b0}};
            settle_r    <= {CNT_W{1'b0}};
            fail_mask_r <= {NUM_GATES{1'b0}};
            fail_gate_r <= {GATE_IDX_W{1'b0}};
            fail_vec_r  <= {GATE_INPUTS{1'b0}};
        end else begin
            state_r     <= state_next_s;
            v_r         <= v_next_s;
            settle_r    <= settle_next_s;
            fail_mask_r <= fail_mask_next_s;
            fail_gate_r <= fail_gate_next_s;
            fail_vec_r  <= fail_vec_next_s;
        end
    end

    // Two-flop synchroniser for the asynchronous chip outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= {NUM_GATES{1'b0}};
            sync2_r <= {NUM_GATES{1'b0}};
        end else begin
            sync1_r <= bus.sense_i;
            sync2_r <= sync1_r;
        end
    end

    // Registered pin drive and status outputs derived from the current state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            drive_r    <= {DRIVE_W{1'b0}};
            drive_en_r <= 1'b0;
            done_r     <= 1'b0;
            rslt_r     <= 1'b0;
            busy_r     <= 1'b0;
            state_o_r  <= 3'd0;
        end else begin
            state_o_r <= state_r;
            case (state_r)
                ST_DRIVE, ST_SAMPLE: begin
                    drive_r    <= drive_vec_s;
                    drive_en_r <= 1'b1;
                    done_r     <= 1'b0;
                    rslt_r     <= 1'b0;
                    busy_r     <= 1'b1;
                end
                ST_DONE: begin
                    drive_r    <= {DRIVE_W{1'b0}};
                    drive_en_r <= 1'b0;
                    done_r     <= 1'b1;
                    rslt_r     <= (fail_mask_r == {NUM_GATES{1'b0}});
                    busy_r     <= 1'b0;
                end
                default: begin
                    drive_r    <= {DRIVE_W{1'b0}};
                    drive_en_r <= 1'b0;
                    done_r     <= 1'b0;
                    rslt_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.drive_o    = drive_r;
    assign bus.drive_en_o = drive_en_r;
    assign bus.Done       = done_r;
    assign bus.RSLT       = rslt_r;
    assign bus.fail_mask  = fail_mask_r;
    assign bus.fail_gate  = fail_gate_r;
    assign bus.fail_vec   = fail_vec_r;
    assign bus.busy       = busy_r;
    assign bus.state_o    = state_o_r;
endmodule

// File: tb/tb_gate_chip_checker.sv
// Testbench for gate_chip_checker. It uses a quad-NAND instance (A) and a
// triple 3-input AND instance (B). Expected results are pushed into
// scoreboard queues when a run is issued. Monitors pop and compare them
// when Done rises or when a SAMPLE step is displayed.
module tb_gate_chip_checker;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   fault_mode = 0;   // 0 good, 1 gate2 stuck-at-1, 2 gate0 ORed into gate1

    typedef struct {
        logic       rslt;
        logic [7:0] mask;
        logic [7:0] gate;
        logic [7:0] vec;
        int         done_cyc;
    } exp_t;

    exp_t       sb_a [$];
    exp_t       sb_b [$];
    logic [7:0] drv_a [$];
    logic [7:0] drv_tab [4];

    gate_chip_checker_if #(.NUM_GATES(4), .GATE_INPUTS(2)) ifa ();
    gate_chip_checker_if #(.NUM_GATES(3), .GATE_INPUTS(3)) ifb ();

    gate_chip_checker #(.NUM_GATES(4), .GATE_INPUTS(2), .TRUTH_TABLE(4'b0111),
                        .SETTLE_CYCLES(4))
        dut_a (.Clk(clk), .Reset(rst_a), .bus(ifa));

    gate_chip_checker #(.NUM_GATES(3), .GATE_INPUTS(3), .TRUTH_TABLE(8'h80),
                        .SETTLE_CYCLES(4))
        dut_b (.Clk(clk), .Reset(rst_b), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chip models: quad NAND with optional faults, triple 3-input AND.
    logic [3:0] sense_a;
    always_comb begin
        for (int g = 0; g < 4; g++) sense_a[g] = ~&ifa.drive_o[g*2 +: 2];
        if (fault_mode == 1) sense_a[2] = 1'b1;
        if (fault_mode == 2) sense_a[1] = sense_a[1] | sense_a[0];
        ifa.sense_i = sense_a;
    end
    always_comb begin
        for (int g = 0; g < 3; g++) ifb.sense_i[g] = &ifb.drive_o[g*3 +: 3];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for A: result on Done rising, drive vector on each displayed SAMPLE.
    logic done_a_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ifa.Done && !done_a_q) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_done", ifa.Done, 1'b0);
            end else begin
                e = sb_a.pop_front();
                check("a_rslt", ifa.RSLT, e.rslt);
                check("a_fail_mask", ifa.fail_mask, e.mask);
                check("a_fail_gate", ifa.fail_gate, e.gate);
                check("a_fail_vec", ifa.fail_vec, e.vec);
                check("a_done_cycle", cyc, e.done_cyc);
                check("a_drive_en_at_done", ifa.drive_en_o, 1'b0);
            end
        end
        if (ifa.state_o == 3'd2) begin
            if (drv_a.size() == 0) check("a_unexpected_sample", ifa.state_o, 3'd1);
            else check("a_drive_step", ifa.drive_o, drv_a.pop_front());
        end
        done_a_q <= ifa.Done;
    end

    // Monitor for B: result on Done rising.
    logic done_b_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ifb.Done && !done_b_q) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_done", ifb.Done, 1'b0);
            end else begin
                e = sb_b.pop_front();
                check("b_rslt", ifb.RSLT, e.rslt);
                check("b_fail_mask", ifb.fail_mask, e.mask);
                check("b_done_cycle", cyc, e.done_cyc);
            end
        end
        done_b_q <= ifb.Done;
    end

    // Called just after a negedge. Run is sampled on the next posedge.
    task automatic start_a(input logic r, input logic [7:0] m, input logic [7:0] g, input logic [7:0] v);
        exp_t e;
        e.rslt = r; e.mask = m; e.gate = g; e.vec = v;
        e.done_cyc = cyc + 1 + 21;
        sb_a.push_back(e);
        for (int i = 0; i < 4; i++) drv_a.push_back(drv_tab[i]);
        ifa.Run = 1'b1;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.Done) break;
        end
        check("a_done_seen", ifa.Done, 1'b1);
    endtask

    task automatic release_a();
        ifa.Run = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero_a(input string p);
        check({p, "_drive_o"}, ifa.drive_o, 8'h00);
        check({p, "_drive_en"}, ifa.drive_en_o, 1'b0);
        check({p, "_done"}, ifa.Done, 1'b0);
        check({p, "_rslt"}, ifa.RSLT, 1'b0);
        check({p, "_fail_mask"}, ifa.fail_mask, 4'h0);
        check({p, "_fail_gate"}, ifa.fail_gate, 2'd0);
        check({p, "_fail_vec"}, ifa.fail_vec, 2'd0);
        check({p, "_busy"}, ifa.busy, 1'b0);
        check({p, "_state"}, ifa.state_o, 3'd0);
    endtask

    initial begin
        exp_t eb;
`ifdef GATE_CHK_ISOLATION_EN
        drv_tab[0] = 8'hE4; drv_tab[1] = 8'h39; drv_tab[2] = 8'h4E; drv_tab[3] = 8'h93;
`else
        drv_tab[0] = 8'h00; drv_tab[1] = 8'h55; drv_tab[2] = 8'hAA; drv_tab[3] = 8'hFF;
`endif
        ifa.Run = 1'b0; ifb.Run = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        check_zero_a("reset");
        check("reset_b_done", ifb.Done, 1'b0);
        check("reset_b_drive_en", ifb.drive_en_o, 1'b0);

        // Good part, then Run held in DONE for 100 cycles.
        start_a(1'b1, 8'h00, 8'd0, 8'd0);
        wait_done_a();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("hold_done", ifa.Done, 1'b1);
            check("hold_not_busy", ifa.busy, 1'b0);
        end
        release_a();
        check("release_state_idle", ifa.state_o, 3'd0);
        check("release_done_low", ifa.Done, 1'b0);

        // Gate 2 stuck at 1.
        fault_mode = 1;
        start_a(1'b0, 8'h04, 8'd2, 8'd3);
        wait_done_a();
        release_a();

        // Fresh sweep on a good part: the failure data must be cleared.
        fault_mode = 0;
        start_a(1'b1, 8'h00, 8'd0, 8'd0);
        wait_done_a();
        release_a();

        // Reset in cycle 10 of a sweep.
        start_a(1'b1, 8'h00, 8'd0, 8'd0);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", ifa.busy, 1'b1);
        rst_a = 1'b1; ifa.Run = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        sb_a.delete();
        drv_a.delete();
        check_zero_a("midreset");

        // Reset takes priority over a simultaneous Run.
        rst_a = 1'b1; ifa.Run = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; ifa.Run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_beats_run", ifa.busy, 1'b0);

        start_a(1'b1, 8'h00, 8'd0, 8'd0);
        wait_done_a();
        release_a();

        // Short from gate 0 output into gate 1 output.
        fault_mode = 2;
`ifdef GATE_CHK_ISOLATION_EN
        start_a(1'b0, 8'h02, 8'd1, 8'd3);
`else
        start_a(1'b1, 8'h00, 8'd0, 8'd0);
`endif
        wait_done_a();
        release_a();
        fault_mode = 0;

        // 7411 triple 3-input AND.
        eb.rslt = 1'b1; eb.mask = 8'h00; eb.gate = 8'd0; eb.vec = 8'd0;
        eb.done_cyc = cyc + 1 + 41;
        sb_b.push_back(eb);
        ifb.Run = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifb.Done) break;
        end
        check("b_done_seen", ifb.Done, 1'b1);
        ifb.Run = 1'b0;
        repeat (3) @(negedge clk);

        check("a_scoreboard_drained", sb_a.size(), 0);
        check("a_drive_queue_drained", drv_a.size(), 0);
        check("b_scoreboard_drained", sb_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
